// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: arbiter state encoding and default parameter values (no ports)
package uart_arb_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// rr_priority_picker: one-hot pick of the first set request at or after ptr, wrapping
// ports: req (request vector), ptr (start index) -> pick (one-hot), any (some request set)
module rr_priority_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);
    logic [NUM_REQ-1:0] rot, low;
    // rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
    assign rot  = NUM_REQ'({req, req} >> ptr);
    assign low  = rot & (-rot);
    assign pick = NUM_REQ'({low, low} << ptr >> NUM_REQ);
    assign any  = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked arbiter feeding one UART TX FIFO
// ports: clock, reset (sync, active-high); req_valid/req_data/req_last/req_ready per requester;
//        fifo_full in, fifo_wr_en/fifo_wr_data out; grant (one-hot owner), busy, timeout pulse
// option: define UART_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT_CYCLES idle owner cycles
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          timeout
);
    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_t              state, state_n;
    logic [NUM_REQ-1:0]      grant_n, pick;
    logic [PW-1:0]           rr_ptr, rr_ptr_n, ptr_after;
    logic                    any_valid, own_valid, own_last, expire, release_msg;
    logic [DATA_WIDTH-1:0]   own_data;

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .PW(PW)) u_picker (
        .req (req_valid),
        .ptr (rr_ptr),
        .pick(pick),
        .any (any_valid)
    );

    always_comb begin
        own_data  = '0;
        ptr_after = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                ptr_after = PW'((i + 1) % NUM_REQ);
            end
        end
    end

    // reset gating keeps a message abandoned by reset from writing in the reset cycle itself
    assign busy         = state == ARB_LOCKED;
    assign own_valid    = |(req_valid & grant);
    assign own_last     = |(req_last & grant);
    assign req_ready    = (busy && !fifo_full && !reset) ? grant : '0;
    assign fifo_wr_en   = |(req_valid & req_ready);
    assign fifo_wr_data = fifo_wr_en ? own_data : '0;
    assign release_msg  = (fifo_wr_en && own_last) || expire;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        idle_cycle;
    assign idle_cycle = busy && !own_valid && !fifo_full;
    assign expire     = idle_cycle && wd_cnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt  <= (idle_cycle && !expire) ? wd_cnt + 16'd1 : '0;
            timeout <= expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        rr_ptr_n = rr_ptr;
        if (state == ARB_IDLE) begin
            if (any_valid) begin
                state_n = ARB_LOCKED;
                grant_n = pick;
            end
        end else if (release_msg) begin
            state_n  = ARB_IDLE;
            grant_n  = '0;
            rr_ptr_n = ptr_after;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            rr_ptr <= rr_ptr_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus, ownership-level reference model, per-cycle compare
module tb_uart_tx_arbiter;
    localparam int NR = 4, DW = 8, TO = 4;

    logic clock = 1'b0, reset = 1'b1, fifo_full = 1'b0;
    logic [NR-1:0] req_valid = '0, req_last = '0, req_ready, grant;
    logic [NR*DW-1:0] req_data = '0;
    logic fifo_wr_en, busy, timeout;
    logic [DW-1:0] fifo_wr_data;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant(grant),
        .busy(busy), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int total = 0, bad = 0;
    int m_owner = -1, m_ptr = 0, m_idle = 0, cyc = 0, to_cnt = 0;
    bit m_to = 1'b0;
    logic [DW-1:0] wr_q[$];
    int wr_c[$], g_q[$];
    logic [NR-1:0] prev_grant = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        logic [NR-1:0] eg, er;
        logic ew;
        logic [DW-1:0] ed;
        eg = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
        er = (m_owner >= 0 && !fifo_full && !reset) ? eg : '0;
        ew = |(er & req_valid);
        ed = '0;
        if (ew) ed = req_data[m_owner*DW +: DW];
        chk("grant", grant, eg);
        chk("busy", busy, m_owner >= 0);
        chk("req_ready", req_ready, er);
        chk("fifo_wr_en", fifo_wr_en, ew);
        chk("fifo_wr_data", fifo_wr_data, ed);
        chk("timeout", timeout, m_to);
        if (fifo_wr_en) begin
            wr_q.push_back(fifo_wr_data);
            wr_c.push_back(cyc);
        end
        if (timeout) to_cnt++;
        if (grant != '0 && prev_grant == '0)
            for (int i = 0; i < NR; i++) if (grant[i]) g_q.push_back(i);
        prev_grant = grant;
        m_to = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_ptr = 0;
            m_idle = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NR; k++)
                if (m_owner < 0 && req_valid[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
            m_idle = 0;
        end else if (ew && req_last[m_owner]) begin
            m_ptr = (m_owner + 1) % NR;
            m_owner = -1;
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            m_idle = (!req_valid[m_owner] && !fifo_full) ? m_idle + 1 : 0;
            if (m_idle == TO) begin
                m_to = 1'b1;
                m_ptr = (m_owner + 1) % NR;
                m_owner = -1;
                m_idle = 0;
            end
`endif
        end
        cyc++;
    end

    initial begin
        int n0, g0, t0;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        logic [DW-1:0] exp_d[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        tick;
        tick;
        reset = 1'b0;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_timeout", timeout, 0);

        // req0 sends 11,22,33
        n0 = wr_q.size();
        req_valid = 4'b0001;
        set_byte(0, 8'h11);
        tick;
        chk("t1_grant", grant, 4'b0001);
        tick;
        set_byte(0, 8'h22);
        tick;
        set_byte(0, 8'h33);
        req_last = 4'b0001;
        tick;
        req_valid = '0;
        req_last = '0;
        chk("t1_grant_clr", grant, 0);
        chk("t1_count", wr_q.size() - n0, 3);
        if (wr_q.size() - n0 == 3) begin
            chk("t1_b0", wr_q[n0], 8'h11);
            chk("t1_b1", wr_q[n0+1], 8'h22);
            chk("t1_b2", wr_q[n0+2], 8'h33);
            chk("t1_consec", wr_c[n0+2] - wr_c[n0], 2);
        end
        chk("t1_model_ptr", m_ptr, 1);
        // rr_ptr=1: req0 and req1 valid, req1 must win
        req_valid = 4'b0011;
        req_last = 4'b0011;
        set_byte(1, 8'h44);
        tick;
        chk("t1_ptr_grant", grant, 4'b0010);
        tick;
        req_valid = '0;
        req_last = '0;
        tick;

        // all four valid, one-byte messages
        do_reset;
        n0 = wr_q.size();
        g0 = g_q.size();
        for (int i = 0; i < NR; i++) set_byte(i, 8'hA0 + 8'(i));
        req_valid = 4'b1111;
        req_last = 4'b1111;
        repeat (10) tick;
        req_valid = '0;
        req_last = '0;
        tick;
        chk("t2_count", wr_q.size() - n0, 5);
        chk("t2_grants", g_q.size() - g0, 5);
        if (wr_q.size() - n0 == 5 && g_q.size() - g0 == 5)
            for (int k = 0; k < 5; k++) begin
                chk("t2_order", g_q[g0+k], exp_g[k]);
                chk("t2_data", wr_q[n0+k], exp_d[k]);
                if (k > 0) chk("t2_gap", wr_c[n0+k] - wr_c[n0+k-1], 2);
            end

        // req2 stalled by fifo_full for 5 cycles
        do_reset;
        req_valid = 4'b0100;
        set_byte(2, 8'h55);
        tick;
        tick;
        fifo_full = 1'b1;
        set_byte(2, 8'h66);
        n0 = wr_q.size();
        repeat (5) tick;
        chk("t3_grant", grant, 4'b0100);
        chk("t3_nowrite", wr_q.size() - n0, 0);
        fifo_full = 1'b0;
        req_last = 4'b0100;
        tick;
        chk("t3_resume_cnt", wr_q.size() - n0, 1);
        if (wr_q.size() > 0) chk("t3_resume_data", wr_q[wr_q.size()-1], 8'h66);
        req_valid = '0;
        req_last = '0;
        tick;

`ifdef UART_ARB_TIMEOUT_EN
        // req1 granted then goes quiet; watchdog hands over to req2
        do_reset;
        req_valid = 4'b0110;
        req_last = 4'b0100;
        set_byte(1, 8'h77);
        set_byte(2, 8'h88);
        tick;
        chk("t4_grant1", grant, 4'b0010);
        tick;
        req_valid = 4'b0100;
        t0 = to_cnt;
        repeat (3) tick;
        chk("t4_no_early", timeout, 0);
        tick;
        chk("t4_timeout", timeout, 1);
        chk("t4_grant_clr", grant, 0);
        tick;
        chk("t4_grant2", grant, 4'b0100);
        chk("t4_to_low", timeout, 0);
        tick;
        req_valid = '0;
        req_last = '0;
        tick;
        chk("t4_pulses", to_cnt - t0, 1);
`else
        // owner idles 1000 cycles with no watchdog
        do_reset;
        req_valid = 4'b0010;
        set_byte(1, 8'h77);
        tick;
        tick;
        req_valid = '0;
        t0 = to_cnt;
        repeat (1000) tick;
        chk("t4_hold_grant", grant, 4'b0010);
        chk("t4_hold_busy", busy, 1);
        chk("t4_no_timeout", to_cnt - t0, 0);
        req_valid = 4'b0010;
        req_last = 4'b0010;
        tick;
        req_valid = '0;
        req_last = '0;
        tick;
`endif

        // reset during req3's second byte
        do_reset;
        req_valid = 4'b1000;
        set_byte(3, 8'h31);
        tick;
        tick;
        set_byte(3, 8'h32);
        reset = 1'b1;
        n0 = wr_q.size();
        tick;
        reset = 1'b0;
        chk("t5_nowrite", wr_q.size() - n0, 0);
        chk("t5_grant", grant, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", req_ready, 0);
        chk("t5_wr_en", fifo_wr_en, 0);
        chk("t5_wr_data", fifo_wr_data, 0);
        chk("t5_timeout", timeout, 0);
        req_valid = 4'b1001;
        tick;
        chk("t5_regrant", grant, 4'b0001);
        req_valid = '0;
        repeat (3) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
